rcv_ctrl: RTL and testbench
===========================

# rcv_ctrl

Receive control block for the serial receiver: it synchronizes the incoming serial line, detects the start bit, and sequences one packet reception. It drives `enable_timer` into the bit timer and consumes that timer's `packet_done`. It samples the stop bit and raises `framing_error` on a bad frame. On a good frame it pulses `load_buffer` and maintains the `data_ready` and `overrun_error` status seen by the reading host.

## Interface
- No parameters. The packet format is fixed by the bit timer: 10 clocks per bit, 9 bits per packet (8 data bits plus the stop bit).
- `clk` input 1: system clock. All state changes on the rising edge.
- `n_rst` input 1: asynchronous, active-low reset.
- `serial_in` input 1: raw serial line. Idle level is 1. Asynchronous to `clk`.
- `packet_done` input 1: one-cycle pulse from the bit timer after the 9th bit strobe.
- `stop_bit` input 1: last bit captured by the shift register. Valid when `packet_done` pulses.
- `data_read` input 1: host has read the received byte. Level-sampled.
- `start_bit_detected` output 1: one-cycle pulse on a synchronized falling edge of `serial_in`.
- `sbc_clear` output 1: clears the stop-bit check for the new packet.
- `enable_timer` output 1: enables the bit timer.
- `load_buffer` output 1: one-cycle pulse that loads the received byte into the receive buffer.
- `framing_error` output 1: the last packet's stop bit was 0.
- `data_ready` output 1: the buffer holds an unread byte.
- `overrun_error` output 1: a byte was loaded while the previous byte was still unread.

## Operation
- **Synchronizer:** flops `s1` → `s2` → `s3`, all reset to 1.
- **Edge detection:** `start_bit_detected` = `s3 & ~s2`, combinational from the flops.
- **State machine:** states IDLE, START, RECEIVE, STOP, CHECK, LOAD. Reset state is IDLE. Outputs decode from the registered state (Moore).
- **IDLE:** all strobes are 0. If `start_bit_detected` = 1, go to START; otherwise stay in IDLE.
- **START:** `sbc_clear` = 1. Always go to RECEIVE on the next edge.
- **RECEIVE:** `enable_timer` = 1. If `packet_done` = 1, go to STOP. `start_bit_detected` pulses caused by data bits are ignored here.
- **STOP:** `enable_timer` = 0. Register `framing_error` <= ~`stop_bit`. Go to CHECK.
- **CHECK:** if `framing_error` = 1, go to IDLE with no load; otherwise go to LOAD.
- **LOAD:** `load_buffer` = 1. Go to IDLE.
- **framing_error register:** cleared to 0 while in START. Otherwise holds its value until the next packet's STOP.
- **data_ready:** set on any edge where the state is LOAD. Cleared on an edge where `data_read` = 1 and the state is not LOAD. If LOAD and `data_read` occur on the same edge, `data_ready` stays 1.
- **overrun_error:** set on a LOAD edge when `data_ready` = 1 and `data_read` = 0. Cleared on an edge where `data_read` = 1 and the state is not LOAD. Set has priority over clear.
- **Reset mid-operation:** everything returns to reset values immediately, state goes to IDLE, and the partial packet is discarded.

## Timing
- **Reset values:** `start_bit_detected` = 0, `sbc_clear` = 0, `enable_timer` = 0, `load_buffer` = 0, `framing_error` = 0, `data_ready` = 0, `overrun_error` = 0.
- **Start-bit latency:** `serial_in` is first sampled 0 at edge A. `start_bit_detected` is high from A+1 to A+2, exactly one cycle. The state is START after A+2 and RECEIVE after A+3.
- **enable_timer:** high continuously from edge A+3 until the edge that samples `packet_done` = 1. It falls at that edge.
- **Edge to load:** `packet_done` is sampled at edge P.
  - State is STOP after P, CHECK after P+1, LOAD after P+2, IDLE after P+3.
  - `framing_error` is valid after P+1.
  - `load_buffer` is high between P+2 and P+3.
  - `data_ready` rises at P+3.
- **Back-to-back frames:** a start edge becomes visible as early as the IDLE cycle after P+3. A start bit whose detect pulse lands in STOP, CHECK, or LOAD is missed. The sender must idle for at least 4 clocks after the stop bit.
- **Glitches:** a `serial_in` glitch shorter than one clock that is never sampled produces no pulse. A sampled glitch starts a frame, which completes with data decided by the timer.

## Test plan
- **Reset:** drive `n_rst` = 0 with `serial_in` = 0 → all outputs 0 and state IDLE. Release `n_rst` with `serial_in` = 1 → no `start_bit_detected`.
- **Good frame:** send start, data 0xA5 LSB-first, stop = 1, at 10 clocks per bit, with the timer model returning `packet_done` → exactly one `start_bit_detected` pulse, one `sbc_clear` cycle, `enable_timer` high until `packet_done`, `load_buffer` pulse at P+2, `data_ready` = 1 at P+3, `framing_error` = 0.
- **Framing error:** same frame with stop = 0 → `framing_error` = 1 at P+2, no `load_buffer`, `data_ready` unchanged. `framing_error` clears during the next frame's START.
- **Overrun:** two good frames with no `data_read` → `overrun_error` = 1 after the second LOAD. Pulse `data_read` = 1 for one cycle → `data_ready` = 0 and `overrun_error` = 0.
- **Simultaneous read:** `data_read` = 1 on the LOAD edge while `data_ready` = 1 → `data_ready` stays 1 and `overrun_error` stays 0.
- **Mid-packet reset:** assert `n_rst` = 0 during RECEIVE → `enable_timer` = 0 immediately, no `load_buffer`. The next valid frame is received normally.

Source files
------------

// File: rtl/rcv_ctrl.sv
// -----------------------------------------------------------------------------
// rcv_ctrl
//
// Receive control for the serial receiver. Synchronizes the raw serial line,
// detects the start-bit falling edge and walks one packet through
// START -> RECEIVE -> STOP -> CHECK -> LOAD. While receiving it enables the
// external bit timer and waits for that timer's packet_done. The stop bit is
// then checked, and a good frame is loaded into the receive buffer. The block
// also keeps the host-visible data_ready / overrun_error status.
//
// Ports
//   clk                 system clock, all state changes on the rising edge
//   n_rst               asynchronous active-low reset
//   serial_in           raw serial line (idle high), asynchronous to clk
//   packet_done         one-cycle pulse from the bit timer after the 9th bit
//   stop_bit            last captured bit, valid from packet_done onwards
//   data_read           host has read the received byte (level)
//   start_bit_detected  one-cycle pulse on a synchronized falling edge
//   sbc_clear           clears the stop-bit check for the new packet
//   enable_timer        enables the bit timer
//   load_buffer         one-cycle pulse that loads the receive buffer
//   framing_error       the last packet's stop bit was 0
//   data_ready          the buffer holds an unread byte
//   overrun_error       a byte was loaded over a still-unread byte
// -----------------------------------------------------------------------------
module rcv_ctrl (
    input  logic clk,
    input  logic n_rst,
    input  logic serial_in,
    input  logic packet_done,
    input  logic stop_bit,
    input  logic data_read,
    output logic start_bit_detected,
    output logic sbc_clear,
    output logic enable_timer,
    output logic load_buffer,
    output logic framing_error,
    output logic data_ready,
    output logic overrun_error
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        RECEIVE = 3'd2,
        STOP    = 3'd3,
        CHECK   = 3'd4,
        LOAD    = 3'd5
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic s1_reg;
    logic s2_reg;
    logic s3_reg;
    logic framing_error_reg;
    logic data_ready_reg;
    logic overrun_error_reg;

    // -------------------------------------------------------------------------
    // Line synchronizer. s1/s2 resolve metastability; s3 is the previous
    // synchronized value used for edge detection. All reset to the idle level
    // so leaving reset never fakes a start edge.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            s1_reg <= 1'b1;
            s2_reg <= 1'b1;
            s3_reg <= 1'b1;
        end else begin
            s1_reg <= serial_in;
            s2_reg <= s1_reg;
            s3_reg <= s2_reg;
        end
    end

    // Falling edge of the synchronized line: old value high, new value low.
    assign start_bit_detected = s3_reg & ~s2_reg;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next state and Moore outputs
    // -------------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        sbc_clear    = 1'b0;
        enable_timer = 1'b0;
        load_buffer  = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start_bit_detected) begin
                    state_next = START;
                end
            end
            START: begin
                sbc_clear  = 1'b1;
                state_next = RECEIVE;
            end
            RECEIVE: begin
                // Falling edges inside the data bits also pulse
                // start_bit_detected; they are simply not looked at here.
                enable_timer = 1'b1;
                if (packet_done) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                state_next = CHECK;
            end
            CHECK: begin
                // framing_error was captured on the STOP edge and is
                // stable now.
                if (framing_error_reg) begin
                    state_next = IDLE;
                end else begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                load_buffer = 1'b1;
                state_next  = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Framing error: cleared as a new packet starts. Captured from the stop
    // bit one edge after packet_done, while the shift register still holds
    // it. Otherwise it keeps its value so the host can see the last result.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            framing_error_reg <= 1'b0;
        end else if (state_reg == START) begin
            framing_error_reg <= 1'b0;
        end else if (state_reg == STOP) begin
            framing_error_reg <= ~stop_bit;
        end
    end

    // -------------------------------------------------------------------------
    // Host status. A load always wins over a read in the same cycle, because
    // that read refers to the byte being replaced. An overrun is only flagged
    // when the old byte was still unread and is not being read right now.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            data_ready_reg    <= 1'b0;
            overrun_error_reg <= 1'b0;
        end else if (state_reg == LOAD) begin
            data_ready_reg <= 1'b1;
            if (data_ready_reg && !data_read) begin
                overrun_error_reg <= 1'b1;
            end
        end else if (data_read) begin
            data_ready_reg    <= 1'b0;
            overrun_error_reg <= 1'b0;
        end
    end

    assign framing_error = framing_error_reg;
    assign data_ready    = data_ready_reg;
    assign overrun_error = overrun_error_reg;

endmodule

// File: tb/tb_rcv_ctrl.sv
module tb_rcv_ctrl;

    logic clk = 1'b0;
    logic n_rst = 1'b1;
    logic serial_in = 1'b1;
    logic packet_done = 1'b0;
    logic stop_bit = 1'b1;
    logic data_read = 1'b0;

    logic start_bit_detected;
    logic sbc_clear;
    logic enable_timer;
    logic load_buffer;
    logic framing_error;
    logic data_ready;
    logic overrun_error;

    always #5 clk = ~clk;

    rcv_ctrl dut (
        .clk                (clk),
        .n_rst              (n_rst),
        .serial_in          (serial_in),
        .packet_done        (packet_done),
        .stop_bit           (stop_bit),
        .data_read          (data_read),
        .start_bit_detected (start_bit_detected),
        .sbc_clear          (sbc_clear),
        .enable_timer       (enable_timer),
        .load_buffer        (load_buffer),
        .framing_error      (framing_error),
        .data_ready         (data_ready),
        .overrun_error      (overrun_error)
    );

    int errors = 0;
    int checks = 0;

    // ---------------------------------------------------------------------
    // Reference model: a timeline of the current frame.
    //   s_edge : clock edge after which the block is in START
    //   p_edge : clock edge that sampled packet_done (-1 while receiving)
    // Everything else follows from fixed offsets to those two edges.
    // ---------------------------------------------------------------------
    int  n = 0;          // number of rising edges seen
    bit  have_frame;
    int  s_edge;
    int  p_edge;
    bit  m_fe, m_dr, m_ov, m_det;
    bit  h0, h1, h2;     // serial samples at edges n, n-1, n-2
    int  rd_mode = 0;    // 0: no reads, 1: random reads, 2: read on load edge
    bit  force_read = 1'b0;
    int  frame_no = 0;

    task automatic check_eq(input string tag, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (edge %0d)", tag, got, exp, n);
        end
    endtask

    function automatic bit m_idle(input int m);
        return !have_frame || (p_edge >= 0 && (m >= p_edge + 3 || (m >= p_edge + 2 && m_fe)));
    endfunction

    function automatic bit m_load(input int m);
        return have_frame && p_edge >= 0 && m == p_edge + 2 && !m_fe;
    endfunction

    task automatic model_reset();
        have_frame = 1'b0;
        s_edge = 0;
        p_edge = -1;
        m_fe = 1'b0;
        m_dr = 1'b0;
        m_ov = 1'b0;
        m_det = 1'b0;
        h0 = 1'b1;
        h1 = 1'b1;
        h2 = 1'b1;
    endtask

    task automatic model_edge();
        bit load_b;
        n++;
        if (!n_rst) begin
            model_reset();
            return;
        end
        load_b = m_load(n - 1);
        if (m_idle(n - 1) && m_det) begin
            have_frame = 1'b1;
            s_edge = n;
            p_edge = -1;
        end else if (have_frame && p_edge < 0 && (n - 1) >= s_edge + 1 && packet_done) begin
            p_edge = n;
        end
        if (have_frame && n == s_edge + 1) m_fe = 1'b0;
        if (have_frame && p_edge >= 0 && n == p_edge + 1) m_fe = ~stop_bit;
        if (load_b) begin
            if (m_dr && !data_read) m_ov = 1'b1;
            m_dr = 1'b1;
        end else if (data_read) begin
            m_dr = 1'b0;
            m_ov = 1'b0;
        end
        h2 = h1;
        h1 = h0;
        h0 = serial_in;
        m_det = h2 & ~h1;
    endtask

    task automatic check_all();
        check_eq("start_bit_detected", start_bit_detected, m_det);
        check_eq("sbc_clear", sbc_clear, have_frame && n == s_edge);
        check_eq("enable_timer", enable_timer, have_frame && p_edge < 0 && n >= s_edge + 1);
        check_eq("load_buffer", load_buffer, m_load(n));
        check_eq("framing_error", framing_error, m_fe);
        check_eq("data_ready", data_ready, m_dr);
        check_eq("overrun_error", overrun_error, m_ov);
    endtask

    // One clock: the bit timer and host are driven from the model timeline,
    // then the edge is taken and outputs are compared on the falling edge.
    task automatic tick();
        bit stray;
        stray = m_idle(n) && ($urandom_range(0, 31) == 0);
        packet_done = (n_rst && have_frame && p_edge < 0 && n == s_edge + 92) || stray;
        case (rd_mode)
            1:       data_read = force_read || ($urandom_range(0, 15) == 0);
            2:       data_read = force_read || m_load(n);
            default: data_read = force_read;
        endcase
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset(input int cycles);
        n_rst = 1'b0;
        #1;
        model_reset();
        check_all();
        serial_in = 1'b1;
        repeat (cycles) tick();
        n_rst = 1'b1;
    endtask

    task automatic gap(input int g);
        serial_in = 1'b1;
        repeat (g) tick();
    endtask

    // Start bit, 8 data bits LSB first, stop bit; 10 clocks per bit.
    // abort_at >= 0 asserts reset at that clock of the frame.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int abort_at);
        int  k;
        logic v;
        k = 0;
        stop_bit = stop;
        for (int b = 0; b < 10; b++) begin
            if (b == 0)      v = 1'b0;
            else if (b == 9) v = stop;
            else             v = d[b - 1];
            for (int c = 0; c < 10; c++) begin
                serial_in = v;
                if (k == abort_at) begin
                    do_reset(1 + int'($urandom_range(0, 2)));
                    $display("frame %0d data=%02h stop=%0d aborted at clock %0d", frame_no, d, stop, abort_at);
                    frame_no++;
                    return;
                end
                tick();
                k++;
            end
        end
        serial_in = 1'b1;
        $display("frame %0d data=%02h stop=%0d rd_mode=%0d -> fe=%0d dr=%0d ov=%0d",
                 frame_no, d, stop, rd_mode, m_fe, m_dr, m_ov);
        frame_no++;
    endtask

    initial begin
        model_reset();
        // Reset with the line held low: everything must stay quiet.
        serial_in = 1'b0;
        #2;
        n_rst = 1'b0;
        #1;
        check_all();
        repeat (4) tick();
        serial_in = 1'b1;
        n_rst = 1'b1;
        repeat (5) tick();

        // Good frame, then a framing error, then an overrun.
        rd_mode = 0;
        send_frame(8'hA5, 1'b1, -1);
        gap(10);
        send_frame(8'hA5, 1'b0, -1);
        gap(10);
        send_frame(8'h3C, 1'b1, -1);
        gap(6);
        force_read = 1'b1;
        tick();
        force_read = 1'b0;
        gap(5);

        // Reads landing exactly on the load edge.
        rd_mode = 2;
        send_frame(8'h81, 1'b1, -1);
        gap(4);
        send_frame(8'h7E, 1'b1, -1);
        gap(8);

        // Reset in the middle of RECEIVE, then a normal frame.
        rd_mode = 0;
        send_frame(8'h55, 1'b1, 40);
        gap(10);
        send_frame(8'h96, 1'b1, -1);
        gap(10);

        // Randomized frames.
        for (int f = 0; f < 30; f++) begin
            int abort;
            rd_mode = int'($urandom_range(0, 2));
            abort = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 99)) : -1;
            send_frame(8'($urandom_range(0, 255)), 1'($urandom_range(0, 3) != 0), abort);
            gap(int'($urandom_range(4, 20)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
